// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and consumer-side signals of the UART receive FIFO
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 3
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_par_err;
  logic                  rx_stp_err;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DEPTH_LOG2:0]   level;
  logic                  almost_full;
  logic                  overflow;
  logic                  ovf_clr;
  logic [7:0]            par_err_cnt;
  logic [7:0]            stp_err_cnt;
  modport master (
    output rx_data, rx_valid, rx_par_err, rx_stp_err, m_ready, ovf_clr,
    input  m_data, m_valid, level, almost_full, overflow, par_err_cnt, stp_err_cnt
  );
  modport slave (
    input  rx_data, rx_valid, rx_par_err, rx_stp_err, m_ready, ovf_clr,
    output m_data, m_valid, level, almost_full, overflow, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind the UART receiver with sticky overflow.
// Define UART_RX_FIFO_ERR_CNT_EN to build the saturating parity/stop-bit error edge counters.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_LEVEL   = 6
) (
  input logic         clk,
  input logic         rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_LVL = (DEPTH_LOG2 + 1)'(AF_LEVEL);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  push, pop, not_empty;
  assign not_empty = level != '0;
  assign pop = not_empty & bus.m_ready;
  // a full FIFO still accepts a byte when the head leaves in the same cycle
  assign push = bus.rx_valid & ((level != FULL_LVL) | pop);
  always_ff @(posedge clk)
    if (push & ~rst) mem[wr_ptr] <= bus.rx_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= (push & ~pop) ? level + 1'b1 : (pop & ~push) ? level - 1'b1 : level;
      overflow <= (bus.rx_valid & ~push) ? 1'b1 : bus.ovf_clr ? 1'b0 : overflow;
    end
  end
  assign bus.m_valid     = not_empty;
  assign bus.m_data      = not_empty ? mem[rd_ptr] : '0;
  assign bus.level       = level;
  assign bus.almost_full = level >= AF_LVL;
  assign bus.overflow    = overflow;
`ifdef UART_RX_FIFO_ERR_CNT_EN
  logic       par_q, stp_q;
  logic [7:0] par_cnt, stp_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q   <= 1'b0;
      stp_q   <= 1'b0;
      par_cnt <= '0;
      stp_cnt <= '0;
    end else begin
      par_q <= bus.rx_par_err;
      stp_q <= bus.rx_stp_err;
      if (bus.rx_par_err & ~par_q & (par_cnt != 8'hff)) par_cnt <= par_cnt + 1'b1;
      if (bus.rx_stp_err & ~stp_q & (stp_cnt != 8'hff)) stp_cnt <= stp_cnt + 1'b1;
    end
  end
  assign bus.par_err_cnt = par_cnt;
  assign bus.stp_err_cnt = stp_cnt;
`else
  logic unused_err;
  assign unused_err      = bus.rx_par_err ^ bus.rx_stp_err;
  assign bus.par_err_cnt = '0;
  assign bus.stp_err_cnt = '0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a queue-based model
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] q[$];
  bit   ovf_m;
  int   par_m, stp_m;
  bit   par_prev, stp_prev;
  uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(3)) bus ();
  uart_rx_fifo dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    bit rv, pe, se, clr, rs, pop, push;
    logic [7:0] d;
    rv = bus.rx_valid; d = bus.rx_data; pe = bus.rx_par_err; se = bus.rx_stp_err;
    clr = bus.ovf_clr; rs = rst;
    pop = q.size() > 0 && bus.m_ready;
    push = rv && (q.size() < 8 || pop);
    @(posedge clk);
    if (rs) begin
      q.delete(); ovf_m = 0; par_m = 0; stp_m = 0; par_prev = 0; stp_prev = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (rv && !push) ovf_m = 1; else if (clr) ovf_m = 0;
      if (pe && !par_prev && par_m < 255) par_m++;
      if (se && !stp_prev && stp_m < 255) stp_m++;
      par_prev = pe; stp_prev = se;
    end
    #1;
    check("m_valid", bus.m_valid, q.size() != 0);
    check("m_data", bus.m_data, q.size() != 0 ? q[0] : 8'h00);
    check("level", bus.level, q.size());
    check("almost_full", bus.almost_full, q.size() >= 6);
    check("overflow", bus.overflow, ovf_m);
`ifdef UART_RX_FIFO_ERR_CNT_EN
    check("par_err_cnt", bus.par_err_cnt, par_m);
    check("stp_err_cnt", bus.stp_err_cnt, stp_m);
`else
    check("par_err_cnt", bus.par_err_cnt, 0);
    check("stp_err_cnt", bus.stp_err_cnt, 0);
`endif
  endtask
  task automatic idle();
    bus.rx_valid = 0; bus.m_ready = 0; bus.ovf_clr = 0;
  endtask
  task automatic push_byte(input logic [7:0] d, input bit rdy);
    bus.rx_valid = 1; bus.rx_data = d; bus.m_ready = rdy;
    tick();
    idle();
  endtask
  task automatic drain();
    bus.m_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    idle();
  endtask
  initial begin
    bus.rx_data = 8'h00; bus.rx_par_err = 0; bus.rx_stp_err = 0;
    idle();
    bus.rx_valid = 1; bus.rx_data = 8'hEE;
    tick();
    rst = 0; bus.rx_valid = 0;
    check("rst_level", bus.level, 0);
    push_byte(8'h55, 0); push_byte(8'hA3, 0); push_byte(8'h0F, 0);
    check("tp1_level", bus.level, 3);
    check("tp1_head", bus.m_data, 8'h55);
    bus.m_ready = 1; tick();
    check("tp1_second", bus.m_data, 8'hA3);
    tick(); tick();
    check("tp1_empty_data", bus.m_data, 0);
    idle();
    for (int i = 1; i <= 9; i++) push_byte(8'(i), 0);
    check("tp2_full", bus.level, 8);
    check("tp2_ovf", bus.overflow, 1);
    drain();
    bus.ovf_clr = 1; tick(); idle();
    check("tp2_ovf_clr", bus.overflow, 0);
    for (int i = 0; i < 8; i++) push_byte(8'(8'h30 + i), 0);
    push_byte(8'h77, 1);
    check("tp3_level", bus.level, 8);
    check("tp3_ovf", bus.overflow, 0);
    drain();
    for (int i = 0; i < 20; i++) begin
      bus.rx_valid = 1; bus.rx_data = 8'($urandom); bus.m_ready = 1;
      tick();
    end
    idle(); tick();
    for (int i = 0; i < 5; i++) begin bus.rx_par_err = 1; tick(); end
    bus.rx_par_err = 0; tick();
    for (int i = 0; i < 300; i++) begin
      bus.rx_stp_err = 1; tick(); bus.rx_stp_err = 0; tick();
    end
`ifdef UART_RX_FIFO_ERR_CNT_EN
    check("tp5_par", bus.par_err_cnt, 1);
    check("tp5_stp", bus.stp_err_cnt, 255);
`endif
    for (int i = 0; i < 3000; i++) begin
      bus.rx_valid = 1'($urandom); bus.rx_data = 8'($urandom);
      bus.m_ready = ($urandom_range(0, 2) == 0);
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
      bus.rx_par_err = 1'($urandom); bus.rx_stp_err = 1'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; idle(); drain();
    for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 0);
    push_byte(8'hFF, 0); push_byte(8'hFF, 0); push_byte(8'hFF, 0); push_byte(8'hFF, 0);
    check("tp6_ovf_before", bus.overflow, 1);
    rst = 1; bus.rx_valid = 1; bus.rx_data = 8'hAB;
    tick();
    rst = 0; idle();
    check("tp6_level", bus.level, 0);
    check("tp6_valid", bus.m_valid, 0);
    check("tp6_ovf", bus.overflow, 0);
    tick();
    check("tp6_not_stored", bus.level, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
